// File: rtl/add_f32.sv
// add_f32: two-stage pipelined IEEE-754 single-precision adder.
// Subnormal inputs are flushed to zero, results round to nearest even,
// and intermediate fields are exported for debug and monitoring.
// Handshake: in_valid qualifies a/b in the same cycle and is always accepted
// (no ready, no back-pressure); out_valid rises exactly two cycles later.
module add_f32 #(
    parameter int WIDTH         = 32,
    parameter int EXPONENTWIDTH = 8,
    parameter int MANTISSAWIDTH = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         sum,
    output logic                     a_greater,
    output logic [EXPONENTWIDTH-1:0] exp_diff,
    output logic [EXPONENTWIDTH-1:0] sum_exp,
    output logic [MANTISSAWIDTH-1:0] mant_sum
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Position of the most significant one, counted from bit 26.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // ---------------- stage 1 combinational ----------------
    logic        a_ge;
    logic [31:0] op_l, op_s;
    logic [7:0]  exp_l, exp_s, d;
    logic [23:0] sig_l, sig_s;
    logic [49:0] shifted;
    logic [26:0] aligned;
    logic [27:0] mag;
    logic        a_nan, b_nan, a_inf, b_inf, special;
    logic [31:0] special_val;

    // Compare magnitudes, align the smaller significand, add or subtract.
    always_comb begin
        a_ge    = a[30:0] >= b[30:0];
        op_l    = a_ge ? a : b;
        op_s    = a_ge ? b : a;
        exp_l   = op_l[30:23];
        exp_s   = op_s[30:23];
        d       = exp_l - exp_s;
        sig_l   = (exp_l == 8'd0) ? 24'd0 : {1'b1, op_l[22:0]};
        sig_s   = (exp_s == 8'd0) ? 24'd0 : {1'b1, op_s[22:0]};
        shifted = {sig_s, 26'd0} >> d;
        // Shifts of 26 or more leave only the sticky bit.
        if (d >= 8'd26) aligned = {26'd0, |sig_s};
        else            aligned = {shifted[49:24], |shifted[23:0]};
        if (op_l[31] == op_s[31]) mag = {1'b0, sig_l, 3'b000} + {1'b0, aligned};
        else                      mag = {1'b0, sig_l, 3'b000} - {1'b0, aligned};

        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) special_val = QNAN;
        else if (a_inf)                                              special_val = a;
        else                                                         special_val = b;
    end

    // ---------------- stage 1 registers ----------------
    logic        s1_valid, s1_sign, s1_special, s1_a_greater;
    logic [7:0]  s1_exp, s1_exp_diff;
    logic [27:0] s1_mag;
    logic [31:0] s1_special_val;

    // Capture aligned sum and side fields; hold when no operation is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_sign        <= 1'b0;
            s1_special     <= 1'b0;
            s1_a_greater   <= 1'b0;
            s1_exp         <= 8'd0;
            s1_exp_diff    <= 8'd0;
            s1_mag         <= 28'd0;
            s1_special_val <= 32'd0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign        <= op_l[31];
                s1_special     <= special;
                s1_a_greater   <= a_ge;
                s1_exp         <= exp_l;
                s1_exp_diff    <= d;
                s1_mag         <= mag;
                s1_special_val <= special_val;
            end
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic [4:0]         lz;
    logic [26:0]        norm;
    logic signed [10:0] e1, e2;
    logic               round_up;
    logic [24:0]        rnd;
    logic [22:0]        frac;
    logic [31:0]        result;

    // Normalize, round to nearest even, then select specials and range limits.
    always_comb begin
        lz = lzc27(s1_mag[26:0]);
        if (s1_mag[27]) begin
            norm = {s1_mag[27:2], s1_mag[1] | s1_mag[0]};
            e1   = $signed({3'b000, s1_exp}) + 11'sd1;
        end else begin
            norm = s1_mag[26:0] << lz;
            e1   = $signed({3'b000, s1_exp}) - $signed({6'b000000, lz});
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
        e2       = e1 + $signed({10'd0, rnd[24]});
        frac     = rnd[24] ? rnd[23:1] : rnd[22:0];

        if (s1_special)              result = s1_special_val;
        else if (s1_mag == 28'd0)    result = 32'd0;
        else if (e2 >= 11'sd255)     result = {s1_sign, 8'hFF, 23'd0};
        else if (e2 <= 11'sd0)       result = {s1_sign, 31'd0};
        else                         result = {s1_sign, e2[7:0], frac};
    end

    // Output registers; hold last result while no operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= 32'd0;
            a_greater <= 1'b0;
            exp_diff  <= 8'd0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum       <= result;
                a_greater <= s1_a_greater;
                exp_diff  <= s1_exp_diff;
            end
        end
    end

    assign sum_exp  = sum[30:23];
    assign mant_sum = sum[22:0];

endmodule

// File: tb/tb_add_f32.sv
// Directed vector bench for add_f32: single issues, back-to-back pipeline
// run, and reset with operations in flight.
module tb_add_f32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sum;
    logic        exp_ag;
    logic [7:0]  exp_diff;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] sum;
  logic        a_greater;
  logic [7:0]  exp_diff;
  logic [7:0]  sum_exp;
  logic [22:0] mant_sum;

  int checks = 0;
  int failures = 0;
  vec_t vecs[16];

  add_f32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .sum(sum), .a_greater(a_greater),
    .exp_diff(exp_diff), .sum_exp(sum_exp), .mant_sum(mant_sum)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " sum"}, sum, v.exp_sum);
    check({tag, " a_greater"}, {31'd0, a_greater}, {31'd0, v.exp_ag});
    check({tag, " exp_diff"}, {24'd0, exp_diff}, {24'd0, v.exp_diff});
    check({tag, " sum_exp"}, {24'd0, sum_exp}, {24'd0, v.exp_sum[30:23]});
    check({tag, " mant_sum"}, {9'd0, mant_sum}, {9'd0, v.exp_sum[22:0]});
  endtask

  task automatic check_zero(input string tag);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " sum"}, sum, 32'd0);
    check({tag, " a_greater"}, {31'd0, a_greater}, 32'd0);
    check({tag, " exp_diff"}, {24'd0, exp_diff}, 32'd0);
    check({tag, " sum_exp"}, {24'd0, sum_exp}, 32'd0);
    check({tag, " mant_sum"}, {9'd0, mant_sum}, 32'd0);
  endtask

  // driver: present one operand pair for a single cycle
  task automatic issue(input vec_t v);
    @(negedge clk);
    a = v.a;
    b = v.b;
    in_valid = 1'b1;
  endtask

  initial begin
    // first seven entries are the arithmetic vectors used in the pipeline run
    vecs[0]  = '{32'h3FC00000, 32'h3E800000, 32'h3FE00000, 1'b1, 8'd2};
    vecs[1]  = '{32'h3FC00000, 32'hBE800000, 32'h3FA00000, 1'b1, 8'd2};
    vecs[2]  = '{32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0, 8'd1};
    vecs[3]  = '{32'h3FC00000, 32'hC0200000, 32'hBF800000, 1'b0, 8'd1};
    vecs[4]  = '{32'h41A66666, 32'h3F99999A, 32'h41B00000, 1'b1, 8'd4};
    vecs[5]  = '{32'h41A66666, 32'hBF99999A, 32'h419CCCCC, 1'b1, 8'd4};
    vecs[6]  = '{32'hC1A66666, 32'hBF99999A, 32'hC1B00000, 1'b1, 8'd4};
    vecs[7]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b1, 8'd0};
    vecs[8]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 8'd0};
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 8'd0};
    vecs[10] = '{32'h3F800000, 32'h00000001, 32'h3F800000, 1'b1, 8'd127};
    vecs[11] = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b1, 8'd24};
    vecs[12] = '{32'h4F000000, 32'h3F800000, 32'h4F000000, 1'b1, 8'd31};
    vecs[13] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1, 8'd128};
    vecs[14] = '{32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b0, 8'd128};
    vecs[15] = '{32'h00000000, 32'h40000000, 32'h40000000, 1'b0, 8'd128};

    rst = 1'b1;
    in_valid = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // single-issue vectors: 2-cycle latency, out_valid low in between
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i]);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d mid out_valid", i), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check_result($sformatf("v%0d", i), vecs[i]);
    end

    // back-to-back pipeline run
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 9) check_result($sformatf("pipe%0d", c - 2), vecs[c - 2]);
      if (c == 9) check("pipe drain out_valid", {31'd0, out_valid}, 32'd0);
      if (c < 7) begin
        a = vecs[c].a;
        b = vecs[c].b;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    // reset with two operations in flight
    issue(vecs[2]);
    issue(vecs[4]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check_zero("rst flight");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst idle%0d out_valid", k), {31'd0, out_valid}, 32'd0);
    end
    issue(vecs[5]);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst fresh mid out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_result("rst fresh", vecs[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_f32.md
# add_f32

Pipelined IEEE-754 single-precision adder for the processing-element datapath. Takes two 32-bit floats, produces their rounded sum two cycles later, and exports intermediate fields (magnitude comparison, exponent difference, result exponent and fraction) for debug and PE-level monitoring. One operation can be accepted per cycle.

## Interface
- WIDTH, 32, total float width
- EXPONENTWIDTH, 8, exponent field width
- MANTISSAWIDTH, 23, stored fraction width (hidden bit not included)

One clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  a/b valid this cycle
- a  input  WIDTH  operand {sign, exp, frac}
- b  input  WIDTH  operand
- out_valid  output  1  outputs valid for the operation issued 2 cycles earlier
- sum  output  WIDTH  {sign, sum_exp, mant_sum}
- a_greater  output  1  1 when |a| >= |b|
- exp_diff  output  EXPONENTWIDTH  larger exponent minus smaller exponent
- sum_exp  output  EXPONENTWIDTH  result exponent field
- mant_sum  output  MANTISSAWIDTH  result fraction field

## Operation
- Magnitude compare: exponent first, then fraction; equal magnitudes give a_greater=1 (a is treated as larger).
- Larger operand L, smaller S. Significands get hidden bit 1 (exp≠0). exp_diff = exp(L) − exp(S).
- S significand right-shifted by exp_diff with guard, round, sticky bits; shifts ≥ 26 leave only sticky.
- Same signs: add significands; different signs: L − S. Result sign = sign(L).
- Normalize: carry out → shift right 1, exp+1; otherwise left-shift by leading-zero count, exp decremented accordingly.
- Rounding: round-to-nearest-even on guard/round/sticky; rounding carry renormalizes (exp+1).
- Exact cancellation → +0 (0x00000000).
- Zero / subnormal inputs (exp=0): treated as ±0 (flush to zero); x + 0 = x.
- Result exponent ≥ 255 → ±infinity (exp 255, frac 0). Result exponent ≤ 0 → ±0 (flush).
- Inf/NaN (exp=255): any NaN → 0x7FC00000; +inf + −inf → 0x7FC00000; otherwise the infinity passes through.
- sum_exp and mant_sum always equal sum[30:23] and sum[22:0].

## Timing
- Stage 1 (edge after in_valid): compare, exp_diff, align, add/subtract registered.
- Stage 2: normalize, round, special-case select registered onto outputs.
- Latency 2 cycles; throughput 1 per cycle; no back-pressure.
- a_greater and exp_diff are delayed to align with sum of the same operation.
- out_valid = in_valid delayed 2 cycles. Outputs hold last value when out_valid=0.
- Reset: all outputs and pipeline registers 0 (out_valid=0, sum=0). Reset mid-operation discards in-flight operations; out_valid is 0 on the first two cycles after rst deasserts unless new in_valid.

## Test plan
- 1.5 + 0.25 (a=0x3FC00000, b=0x3E800000) → sum 0x3FE00000, a_greater=1, exp_diff=2, sum_exp=127, mant_sum=0x600000; with b sign set (0xBE800000) → 0x3FA00000.
- 1.5 + 2.5 (b=0x40200000) → 0x40800000, a_greater=0, exp_diff=1, sum_exp=129, mant_sum=0; 1.5 − 2.5 (b=0xC0200000) → 0xBF800000.
- Rounding: 0x41A66666 + 0x3F99999A → 0x41B00000; 0x41A66666 + 0xBF99999A → 0x419CCCCC; 0xC1A66666 + 0xBF99999A → 0xC1B00000.
- Specials: 0x3F800000 + 0xBF800000 → 0x00000000; 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000; 0x7F800000 + 0xFF800000 → 0x7FC00000; 0x3F800000 + 0x00000001 → 0x3F800000.
- Pipeline: back-to-back in_valid for the seven arithmetic vectors above → matching results on consecutive cycles, each exactly 2 cycles after issue, out_valid high throughout.
- Reset: assert rst with two operations in flight → next cycle all outputs 0, out_valid stays 0 until 2 cycles after a fresh in_valid.
